// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer driving a reg_alu register-file/ALU datapath
module reg_alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        carry_flag,
  output logic [7:0]  retired_count,
  output logic        rf_sel,
  output logic        rf_wr,
  output logic [1:0]  rf_op,
  output logic [2:0]  rf_rd_addr_a,
  output logic [2:0]  rf_rd_addr_b,
  output logic [2:0]  rf_wr_addr,
  output logic [7:0]  rf_d_in,
  input  logic [7:0]  rf_d_out_a,
  input  logic [7:0]  rf_d_out_b,
  input  logic        rf_cout
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [1:0] K_LDI = 2'b00, K_ALU = 2'b01, K_RD = 2'b10, K_NOP = 2'b11;
  state_t state;
  logic [15:0] ir;
  logic [1:0] kind;
  logic is_alu, rd_phase;
  logic unused;
  assign kind = ir[15:14];
  assign is_alu = kind == K_ALU;
  assign rd_phase = state == READ || (state == WRITE && is_alu);
  assign unused = ^rf_d_out_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir <= '0;
      rsp_data <= '0;
      carry_flag <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          ir <= instr;
          state <= instr[15:14] == K_LDI ? WRITE : instr[15:14] == K_NOP ? IDLE : READ;
          if (instr[15:14] == K_NOP) retired_count <= retired_count + 8'd1;
        end
        READ: begin
          if (kind == K_RD) rsp_data <= rf_d_out_a;
          state <= kind == K_RD ? RESP : WRITE;
        end
        WRITE: begin
          if (is_alu) carry_flag <= rf_cout;
          retired_count <= retired_count + 8'd1;
          state <= IDLE;
        end
        RESP: if (rsp_ready) begin
          retired_count <= retired_count + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign instr_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // the write strobe is gated by reset so a write in flight never lands at the reset edge
  assign rf_wr = state == WRITE && !reset;
  assign rf_sel = state == WRITE && is_alu;
  assign rf_wr_addr = state != WRITE ? 3'd0 : is_alu ? ir[11:9] : ir[13:11];
  assign rf_d_in = state == WRITE && kind == K_LDI ? ir[7:0] : 8'd0;
  assign rf_rd_addr_a = rd_phase ? ir[8:6] : 3'd0;
  assign rf_rd_addr_b = rd_phase ? ir[5:3] : 3'd0;
  assign rf_op = rd_phase ? ir[13:12] : 2'd0;
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed self-checking bench for reg_alu_seq with a behavioral reg_alu
module tb_reg_alu_seq;
  logic clk = 0, reset = 1, alu_reset = 1;
  logic instr_valid = 0, rsp_ready = 0;
  logic [15:0] instr = '0;
  logic instr_ready, rsp_valid, carry_flag, rf_sel, rf_wr, rf_cout;
  logic [7:0] rsp_data, retired_count, rf_d_in, rf_d_out_a, rf_d_out_b;
  logic [1:0] rf_op;
  logic [2:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [7:0] rf [8];
  logic [8:0] alu_res;
  int vectors = 0, miscompares = 0, wr_cnt = 0, wr_before;
  always #5 clk = ~clk;
  reg_alu_seq dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .carry_flag(carry_flag), .retired_count(retired_count), .rf_sel(rf_sel), .rf_wr(rf_wr),
    .rf_op(rf_op), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in), .rf_d_out_a(rf_d_out_a),
    .rf_d_out_b(rf_d_out_b), .rf_cout(rf_cout)
  );
  assign rf_d_out_a = rf[rf_rd_addr_a];
  assign rf_d_out_b = rf[rf_rd_addr_b];
  assign alu_res = rf_op == 2'd0 ? {1'b0, rf_d_out_a} + {1'b0, rf_d_out_b} :
                   rf_op == 2'd1 ? {1'b0, rf_d_out_a} - {1'b0, rf_d_out_b} :
                   rf_op == 2'd2 ? {1'b0, rf_d_out_a & rf_d_out_b} : {1'b0, rf_d_out_a | rf_d_out_b};
  assign rf_cout = alu_res[8];
  always @(posedge clk) begin
    if (alu_reset) for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
    else if (rf_wr) rf[rf_wr_addr] <= rf_sel ? alu_res[7:0] : rf_d_in;
    wr_cnt <= wr_cnt + int'(rf_wr);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [15:0] w);
    instr = w;
    instr_valid = 1;
    chk("instr_ready_before_issue", 16'(instr_ready), 16'd1);
    tick();
    instr_valid = 0;
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    alu_reset = 0;
    chk("rst_instr_ready", 16'(instr_ready), 16'd1);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_data", 16'(rsp_data), 16'd0);
    chk("rst_carry", 16'(carry_flag), 16'd0);
    chk("rst_retired", 16'(retired_count), 16'd0);
    chk("rst_rf_bus", {rf_wr, rf_sel, rf_op, rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}, 16'd0);
    chk("rst_rf_d_in", 16'(rf_d_in), 16'd0);
    // LDI r3 <- 5A then RD r3
    issue(16'h185A);
    chk("ldi_write", {rf_wr, rf_sel, instr_ready, 2'b0, rf_wr_addr, rf_d_in}, {3'b100, 2'b0, 3'd3, 8'h5A});
    tick();
    chk("ldi_idle_wr", 16'(rf_wr), 16'd0);
    chk("ldi_retired", 16'(retired_count), 16'd1);
    rsp_ready = 1;
    issue(16'h80C0);
    chk("rd_read_addr", 16'(rf_rd_addr_a), 16'd3);
    chk("rd_read_wr", 16'(rf_wr), 16'd0);
    tick();
    chk("rd_resp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("rd_resp_data", 16'(rsp_data), 16'h5A);
    chk("rd_resp_ready_low", 16'(instr_ready), 16'd0);
    tick();
    chk("rd_valid_drop", 16'(rsp_valid), 16'd0);
    chk("rd_retired", 16'(retired_count), 16'd2);
    // F0 + 20 into r4 with carry out
    issue(16'h08F0);
    tick();
    issue(16'h1020);
    tick();
    issue(16'h4850);
    chk("alu_read", {rf_wr, rf_sel, rf_op, 6'd0, rf_rd_addr_a, rf_rd_addr_b}, {4'b0000, 6'd0, 3'd1, 3'd2});
    tick();
    chk("alu_write", {rf_wr, rf_sel, rf_op, 3'd0, rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b}, {4'b1100, 3'd0, 3'd4, 3'd1, 3'd2});
    tick();
    chk("alu_carry", 16'(carry_flag), 16'd1);
    chk("alu_retired", 16'(retired_count), 16'd5);
    chk("alu_idle_addr", {rf_op, rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}, 16'd0);
    issue(16'h8100);
    tick();
    chk("alu_sum_r4", 16'(rsp_data), 16'h10);
    tick();
    chk("alu_rd_retired", 16'(retired_count), 16'd6);
    // response held for 5 cycles of backpressure
    rsp_ready = 0;
    issue(16'h8100);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, instr_ready, 6'd0, rsp_data}, {2'b10, 6'd0, 8'h10});
      tick();
    end
    rsp_ready = 1;
    chk("bp_still_valid", 16'(rsp_valid), 16'd1);
    tick();
    chk("bp_release", {14'd0, rsp_valid, instr_ready}, 16'b01);
    chk("bp_retired", 16'(retired_count), 16'd7);
    // reset during the WRITE of ALU dst=r5
    issue(16'h4A50);
    tick();
    chk("rst_mid_in_write", 16'(dut.state == dut.WRITE), 16'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid_state", {carry_flag, rf_wr, instr_ready, 5'd0, retired_count}, {3'b001, 5'd0, 8'd0});
    issue(16'h8140);
    tick();
    chk("rst_mid_r5", 16'(rsp_data), 16'h00);
    tick();
    chk("rst_mid_retired", 16'(retired_count), 16'd1);
    // dst == srcA: r1 = 3 + 4
    issue(16'h0803);
    tick();
    issue(16'h1004);
    tick();
    wr_before = wr_cnt;
    issue(16'h4250);
    tick();
    tick();
    chk("self_wr_once", 16'(wr_cnt - wr_before), 16'd1);
    chk("self_no_carry", 16'(carry_flag), 16'd0);
    issue(16'h8040);
    tick();
    chk("self_r1", 16'(rsp_data), 16'h07);
    tick();
    chk("self_retired", 16'(retired_count), 16'd5);
    // 256 back-to-back NOPs from a cleared counter
    reset = 1;
    tick();
    reset = 0;
    wr_before = wr_cnt;
    instr = 16'hC000;
    instr_valid = 1;
    tick();
    chk("nop_first", 16'(retired_count), 16'd1);
    for (int i = 1; i < 255; i++) tick();
    chk("nop_255", {instr_ready, 7'd0, retired_count}, {1'b1, 7'd0, 8'd255});
    tick();
    instr_valid = 0;
    chk("nop_wrap", 16'(retired_count), 16'd0);
    chk("nop_no_wr", 16'(wr_cnt - wr_before), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
